cascade_cmp_ctrl: RTL and testbench



---
 rtl/cascade_cmp_ctrl.sv | 112 +++++++++++
 tb/tb_cascade_cmp_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_cmp_ctrl.sv
// Sequencer that compares two wide unsigned operands one nibble per clock,
// MSB-first, through a shared external 4-bit magnitude comparator.
module cascade_cmp_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    output logic [3:0]             cmp_a,
    output logic [3:0]             cmp_b,
    input  logic [2:0]             cmp_o,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             result,
    output logic                   err,
    output logic [2:0]             nib_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [4*NIBBLES-1:0] a_reg, b_reg, a_reg_n, b_reg_n;
    logic [2:0]           nib_idx_n;
    logic [2:0]           result_n;
    logic                 err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            nib_idx <= 3'd0;
            result  <= 3'b000;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            a_reg   <= a_reg_n;
            b_reg   <= b_reg_n;
            nib_idx <= nib_idx_n;
            result  <= result_n;
            err     <= err_n;
        end
    end

    // Any comparator code that is not one-hot flags err and ends the compare.
    always_comb begin
        state_n   = state;
        a_reg_n   = a_reg;
        b_reg_n   = b_reg;
        nib_idx_n = nib_idx;
        result_n  = result;
        err_n     = err;
        cmp_a     = 4'd0;
        cmp_b     = 4'd0;

        case (state)
            IDLE: begin
                if (start) begin
                    a_reg_n   = a_in;
                    b_reg_n   = b_in;
                    nib_idx_n = 3'(NIBBLES - 1);
                    result_n  = 3'b000;
                    err_n     = 1'b0;
                    state_n   = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (nib_idx == 3'(i)) begin
                        cmp_a = a_reg[4*i +: 4];
                        cmp_b = b_reg[4*i +: 4];
                    end
                end
                case (cmp_o)
                    3'b100, 3'b001: begin
                        result_n = cmp_o;
                        state_n  = DONE;
                    end
                    3'b010: begin
                        if (nib_idx == 3'd0) begin
                            result_n = 3'b010;
                            state_n  = DONE;
                        end else begin
                            nib_idx_n = nib_idx - 3'd1;
                        end
                    end
                    default: begin
                        err_n    = 1'b1;
                        result_n = 3'b000;
                        state_n  = DONE;
                    end
                endcase
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cascade_cmp_ctrl.sv
// Directed bench for cascade_cmp_ctrl; a behavioural 4-bit comparator stub
// sits on cmp_a/cmp_b and can be forced to return an illegal code.
module tb_cascade_cmp_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  cmp_a;
    logic [3:0]  cmp_b;
    logic [2:0]  cmp_o;
    logic        busy;
    logic        done;
    logic [2:0]  result;
    logic        err;
    logic [2:0]  nib_idx;

    logic        force_bad;
    logic [2:0]  bad_code;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    cascade_cmp_ctrl #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cmp_a   (cmp_a),
        .cmp_b   (cmp_b),
        .cmp_o   (cmp_o),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err),
        .nib_idx (nib_idx)
    );

    assign cmp_o = force_bad ? bad_code
                             : {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive this cycle's inputs, then step to #1 after the next rising edge.
    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b);
        start = s;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        force_bad = 1'b0; bad_code = 3'b000;

        // Reset state
        applyStimulus(0, 16'h0, 16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        rst = 1'b0;
        checkOutput("rst_busy",   16'(busy),    16'h0);
        checkOutput("rst_done",   16'(done),    16'h0);
        checkOutput("rst_result", 16'(result),  16'h0);
        checkOutput("rst_err",    16'(err),     16'h0);
        checkOutput("rst_cmp_a",  16'(cmp_a),   16'h0);
        checkOutput("rst_cmp_b",  16'(cmp_b),   16'h0);
        checkOutput("rst_idx",    16'(nib_idx), 16'h0);

        // Equal operands walk all four nibbles
        applyStimulus(1, 16'h1234, 16'h1234);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("t1_busy",  16'(busy),    16'h1);
            checkOutput("t1_done",  16'(done),    16'h0);
            checkOutput("t1_cmp_a", 16'(cmp_a),   16'(k));
            checkOutput("t1_cmp_b", 16'(cmp_b),   16'(k));
            checkOutput("t1_idx",   16'(nib_idx), 16'(4 - k));
            applyStimulus(0, 16'h1234, 16'h1234);
        end
        checkOutput("t1_done5",   16'(done),   16'h1);
        checkOutput("t1_busy5",   16'(busy),   16'h1);
        checkOutput("t1_result",  16'(result), 16'h2);
        checkOutput("t1_err",     16'(err),    16'h0);
        checkOutput("t1_cmp_a5",  16'(cmp_a),  16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t1_done6",   16'(done),   16'h0);
        checkOutput("t1_busy6",   16'(busy),   16'h0);
        checkOutput("t1_hold6",   16'(result), 16'h2);

        // Early exit on MSB nibble
        applyStimulus(1, 16'h9000, 16'h8FFF);
        checkOutput("t2_cmp_a",   16'(cmp_a),  16'h9);
        checkOutput("t2_cmp_b",   16'(cmp_b),  16'h8);
        checkOutput("t2_clr",     16'(result), 16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t2_done",    16'(done),   16'h1);
        checkOutput("t2_result",  16'(result), 16'h4);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t2_done3",   16'(done),   16'h0);

        // Difference only in LSB nibble, then hold
        applyStimulus(1, 16'h1230, 16'h1231);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("t3_busy", 16'(busy), 16'h1);
            checkOutput("t3_done", 16'(done), 16'h0);
            applyStimulus(0, 16'h0, 16'h0);
        end
        checkOutput("t3_done5",   16'(done),   16'h1);
        checkOutput("t3_result",  16'(result), 16'h1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 16'h0, 16'h0);
            checkOutput("t3_hold",      16'(result), 16'h1);
            checkOutput("t3_hold_done", 16'(done),   16'h0);
        end

        // Starts while busy are ignored; operand changes have no effect
        applyStimulus(1, 16'h0001, 16'h0001);
        applyStimulus(0, 16'h0001, 16'h0001);
        applyStimulus(1, 16'hFFFF, 16'h0000);
        checkOutput("t4_cmp_a3",  16'(cmp_a),  16'h0);
        checkOutput("t4_cmp_b3",  16'(cmp_b),  16'h0);
        applyStimulus(0, 16'hFFFF, 16'h0000);
        checkOutput("t4_cmp_a4",  16'(cmp_a),  16'h1);
        checkOutput("t4_cmp_b4",  16'(cmp_b),  16'h1);
        applyStimulus(0, 16'hFFFF, 16'h0000);
        checkOutput("t4_done5",   16'(done),   16'h1);
        checkOutput("t4_result5", 16'(result), 16'h2);
        applyStimulus(1, 16'hFFFF, 16'h0000);
        checkOutput("t4_busy6",   16'(busy),   16'h0);
        applyStimulus(1, 16'hFFFF, 16'h0000);
        checkOutput("t4_cmp_a7",  16'(cmp_a),  16'hF);
        checkOutput("t4_cmp_b7",  16'(cmp_b),  16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t4_done8",   16'(done),   16'h1);
        checkOutput("t4_result8", 16'(result), 16'h4);
        applyStimulus(0, 16'h0, 16'h0);

        // Reset in the middle of a compare
        applyStimulus(1, 16'h1234, 16'h1234);
        applyStimulus(0, 16'h0, 16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t5_busy3",   16'(busy),   16'h1);
        checkOutput("t5_cmp_a3",  16'(cmp_a),  16'h3);
        rst = 1'b1;
        applyStimulus(0, 16'h0, 16'h0);
        rst = 1'b0;
        checkOutput("t5_busy4",   16'(busy),    16'h0);
        checkOutput("t5_done4",   16'(done),    16'h0);
        checkOutput("t5_result4", 16'(result),  16'h0);
        checkOutput("t5_cmp_a4",  16'(cmp_a),   16'h0);
        checkOutput("t5_cmp_b4",  16'(cmp_b),   16'h0);
        checkOutput("t5_idx4",    16'(nib_idx), 16'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 16'h0, 16'h0);
            checkOutput("t5_nodone", 16'(done), 16'h0);
        end
        applyStimulus(1, 16'h00FF, 16'h0100);
        checkOutput("t5_busy_r",  16'(busy),   16'h1);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t5_cmp_a_r", 16'(cmp_a),  16'h0);
        checkOutput("t5_cmp_b_r", 16'(cmp_b),  16'h1);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t5_done_r",  16'(done),   16'h1);
        checkOutput("t5_res_r",   16'(result), 16'h1);
        applyStimulus(0, 16'h0, 16'h0);

        // Simultaneous rst and start: reset wins
        rst = 1'b1;
        applyStimulus(1, 16'h1111, 16'h2222);
        rst = 1'b0;
        checkOutput("t5b_busy",   16'(busy),   16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t5b_busy2",  16'(busy),   16'h0);

        // Illegal comparator codes
        force_bad = 1'b1; bad_code = 3'b000;
        applyStimulus(1, 16'h5555, 16'h5555);
        checkOutput("t6_busy1",   16'(busy),   16'h1);
        applyStimulus(0, 16'h0, 16'h0);
        force_bad = 1'b0;
        checkOutput("t6_done2",   16'(done),   16'h1);
        checkOutput("t6_err2",    16'(err),    16'h1);
        checkOutput("t6_res2",    16'(result), 16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t6_errhold", 16'(err),    16'h1);

        force_bad = 1'b1; bad_code = 3'b110;
        applyStimulus(1, 16'h5555, 16'h5555);
        checkOutput("t6_errclr",  16'(err),    16'h0);
        applyStimulus(0, 16'h0, 16'h0);
        force_bad = 1'b0;
        checkOutput("t6_done_b",  16'(done),   16'h1);
        checkOutput("t6_err_b",   16'(err),    16'h1);
        checkOutput("t6_res_b",   16'(result), 16'h0);
        applyStimulus(0, 16'h0, 16'h0);

        applyStimulus(1, 16'h0002, 16'h0001);
        checkOutput("t6_good_err1", 16'(err), 16'h0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 16'h0, 16'h0);
        checkOutput("t6_good_done", 16'(done),   16'h1);
        checkOutput("t6_good_res",  16'(result), 16'h4);
        checkOutput("t6_good_err",  16'(err),    16'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
